// File: rtl/io_bridge_pkg.sv
// Shared constants for io_bridge: I/O window select bit, register word addresses,
// STATUS bit positions and the register decoder.
package io_bridge_pkg;

  localparam int IO_SEL_BIT = 11;

  localparam logic [11:0] IO_TXDATA = 12'h800;
  localparam logic [11:0] IO_STATUS = 12'h804;
  localparam logic [11:0] IO_CYCLES = 12'h808;
  localparam logic [11:0] IO_HALT   = 12'hFFC;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TXDATA,
    REG_STATUS,
    REG_CYCLES,
    REG_HALT
  } io_reg_e;

  // Takes the word address (address[11:2]); byte offset bits never matter.
  function automatic io_reg_e decode_reg(input logic [9:0] word_addr);
    io_reg_e sel;
    sel = REG_NONE;
    if (word_addr == IO_TXDATA[11:2]) sel = REG_TXDATA;
    if (word_addr == IO_STATUS[11:2]) sel = REG_STATUS;
    if (word_addr == IO_CYCLES[11:2]) sel = REG_CYCLES;
    if (word_addr == IO_HALT[11:2])   sel = REG_HALT;
    return sel;
  endfunction

endpackage

// File: rtl/io_bridge_sync_fifo.sv
// Synchronous FIFO with registered head output; a push while full is accepted only
// if a pop happens in the same cycle, otherwise it is dropped and flagged.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dropped = push && full && !do_pop;

    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);

    count = count_q;
    rdata = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a flushed FIFO never exposes stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: passes ordinary accesses to memory and serves the
// address[11] window (TX FIFO, STATUS, CYCLES, HALT). Optional: IO_BRIDGE_CYCLE_COUNTER_EN.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] address,
  input  logic [31:0]   data_out,
  input  logic          we,
  output logic [31:0]   data_in,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  output logic          tx_valid,
  output logic [31:0]   tx_data,
  input  logic          tx_ready,
  output logic          halt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          io_sel;
  io_reg_e       reg_sel;
  logic          first_wr, push, pop, status_clr;
  logic          fifo_full, fifo_empty, fifo_dropped;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word, cycles_val, io_rdata;

  logic          prev_we_q, prev_we_d;
  logic [AW-1:0] prev_addr_q, prev_addr_d;
  logic          overflow_q, overflow_d;
  logic          halt_q, halt_d;

  // A held write only acts on its first cycle, so a stalled core cannot multi-push.
  always_comb begin
    io_sel     = address[IO_SEL_BIT];
    reg_sel    = io_sel ? decode_reg(address[11:2]) : REG_NONE;
    first_wr   = we && !(prev_we_q && (prev_addr_q == address));
    push       = first_wr && (reg_sel == REG_TXDATA);
    status_clr = first_wr && (reg_sel == REG_STATUS);
    pop        = !fifo_empty && tx_ready;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .wdata   (data_out),
    .pop     (pop),
    .rdata   (tx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .dropped (fifo_dropped)
  );

`ifdef IO_BRIDGE_CYCLE_COUNTER_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cycles_q <= '0;
    else         cycles_q <= cycles_d;
  end

  assign cycles_val = cycles_q;
`else
  assign cycles_val = '0;
`endif

  always_comb begin
    status_word                           = '0;
    status_word[STAT_COUNT_LSB +: 8]      = 8'(fifo_count);
    status_word[STAT_OVERFLOW]            = overflow_q;
    status_word[STAT_FULL]                = fifo_full;
    status_word[STAT_EMPTY]               = fifo_empty;

    case (reg_sel)
      REG_STATUS: io_rdata = status_word;
      REG_CYCLES: io_rdata = cycles_val;
      default:    io_rdata = '0;
    endcase

    mem_we   = we && !io_sel;
    data_in  = io_sel ? io_rdata : mem_rdata;
    tx_valid = !fifo_empty;
    halt     = halt_q;
  end

  always_comb begin
    prev_we_d   = we;
    prev_addr_d = address;
    overflow_d  = overflow_q;
    if (status_clr)   overflow_d = 1'b0;
    if (fifo_dropped) overflow_d = 1'b1;
    halt_d = halt_q || (reg_sel == REG_HALT);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_we_q   <= 1'b0;
      prev_addr_q <= '0;
      overflow_q  <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      prev_we_q   <= prev_we_d;
      prev_addr_q <= prev_addr_d;
      overflow_q  <= overflow_d;
      halt_q      <= halt_d;
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge against a queue-based reference model of the bus map.
// Honours IO_BRIDGE_CYCLE_COUNTER_EN for CYCLES expectations.
module tb_io_bridge;

  localparam int DEPTH = 8;

  logic        clk;
  logic        resetn;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        we;
  logic [31:0] data_in;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        halt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          m_over;
  bit          m_halt;
  logic [31:0] m_cycles;
  bit          m_prev_we;
  logic [31:0] m_prev_addr;

  logic [31:0] bench_mem [256];

  io_bridge #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .address   (address),
    .data_out  (data_out),
    .we        (we),
    .data_in   (data_in),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .halt      (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple memory behind the bridge
  always @(posedge clk) if (mem_we) bench_mem[address[9:2]] <= data_out;
  assign mem_rdata = bench_mem[address[9:2]];

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(q.size()) << 8;
    if (m_over)            s = s | 32'h4;
    if (q.size() == DEPTH) s = s | 32'h2;
    if (q.size() == 0)     s = s | 32'h1;
    return s;
  endfunction

  function automatic logic [31:0] exp_cycles();
`ifdef IO_BRIDGE_CYCLE_COUNTER_EN
    return m_cycles;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_edge();
    bit first, popped, was_full, in_window;
    logic [11:0] word;
    if (!resetn) begin
      q.delete();
      m_over = 0; m_halt = 0; m_cycles = 0; m_prev_we = 0; m_prev_addr = 0;
      return;
    end
    in_window = address[11];
    word      = {address[11:2], 2'b00};
    first     = we && !(m_prev_we && m_prev_addr == address);
    was_full  = (q.size() == DEPTH);
    popped    = (q.size() != 0) && tx_ready;
    if (popped) void'(q.pop_front());
    if (first && in_window && word == 12'h800) begin
      if (was_full && !popped) m_over = 1;
      else                     q.push_back(data_out);
    end
    if (first && in_window && word == 12'h804) m_over = 0;
    if (in_window && word == 12'hFFC) m_halt = 1;
    m_cycles    = m_cycles + 32'd1;
    m_prev_we   = we;
    m_prev_addr = address;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    address = 32'h800; data_out = w; we = 1'b1;
    tick();
    we = 1'b0;
    tick();
  endtask

  task automatic drain_fifo();
    tx_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; we = 1'b0; address = 32'h0; data_out = '0; tx_ready = 1'b0;
    tick(); tick();
    resetn = 1'b1; address = 32'h804;
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++;
    if (halt !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt: got %b expected 0", halt); end
    checks++;
    if (data_in !== 32'h1) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00000001", data_in); end
  endtask

  task automatic test_mem_access();
    address = 32'h010; data_out = 32'h1234; we = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL mem_we_on_write: got %b expected 1", mem_we); end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (data_in !== 32'h1234) begin errors++; $display("[TB] FAIL mem_readback: got %h expected 00001234", data_in); end
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL mem_tx_valid: got %b expected 0", tx_valid); end
  endtask

  task automatic test_held_write();
    tx_ready = 1'b0; address = 32'h800; data_out = 32'hA5; we = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL io_mem_we: got %b expected 0", mem_we); end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 32'hA5)
      begin errors++; $display("[TB] FAIL held_first_word: got valid=%b data=%h expected valid=1 data=000000a5", tx_valid, tx_data); end
    tick(); tick();
    we = 1'b0; address = 32'h804;
    #1;
    checks++;
    if (data_in !== 32'h0000_0100) begin errors++; $display("[TB] FAIL held_status: got %h expected 00000100", data_in); end
    drain_fifo();
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) push_word(32'h100 + 32'(i));
    address = 32'h804;
    #1;
    checks++;
    if (data_in !== 32'h0000_0806) begin errors++; $display("[TB] FAIL overflow_status: got %h expected 00000806", data_in); end
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 32'h100 + 32'(i))
        begin errors++; $display("[TB] FAIL overflow_drain_%0d: got valid=%b data=%h expected %h", i, tx_valid, tx_data, 32'h100 + 32'(i)); end
      tick();
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL overflow_empty: got %b expected 0", tx_valid); end
    checks++;
    if (data_in !== 32'h5) begin errors++; $display("[TB] FAIL overflow_sticky: got %h expected 00000005", data_in); end
    we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (data_in !== 32'h1) begin errors++; $display("[TB] FAIL overflow_clear: got %h expected 00000001", data_in); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] want;
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word(32'h200 + 32'(i));
    tx_ready = 1'b1; address = 32'h800; data_out = 32'h77; we = 1'b1;
    tick();
    we = 1'b0; tx_ready = 1'b0; address = 32'h804;
    #1;
    checks++;
    if (data_in !== 32'h0000_0802) begin errors++; $display("[TB] FAIL fullpp_status: got %h expected 00000802", data_in); end
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      want = (i < DEPTH - 1) ? 32'h201 + 32'(i) : 32'h77;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== want)
        begin errors++; $display("[TB] FAIL fullpp_drain_%0d: got valid=%b data=%h expected %h", i, tx_valid, tx_data, want); end
      tick();
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL fullpp_empty: got %b expected 0", tx_valid); end
  endtask

  task automatic test_cycles();
    logic [31:0] r1, r2;
    address = 32'h808; we = 1'b0;
    #1;
    r1 = data_in;
    repeat (10) tick();
    r2 = data_in;
`ifdef IO_BRIDGE_CYCLE_COUNTER_EN
    checks++;
    if (r2 - r1 !== 32'd10) begin errors++; $display("[TB] FAIL cycles_delta: got %0d expected 10", r2 - r1); end
    checks++;
    if (r2 !== m_cycles) begin errors++; $display("[TB] FAIL cycles_value: got %0d expected %0d", r2, m_cycles); end
`else
    checks++;
    if (r1 !== 32'h0) begin errors++; $display("[TB] FAIL cycles_zero_a: got %h expected 0", r1); end
    checks++;
    if (r2 !== 32'h0) begin errors++; $display("[TB] FAIL cycles_zero_b: got %h expected 0", r2); end
`endif
  endtask

  task automatic test_halt();
    tx_ready = 1'b0;
    push_word(32'h55);
    address = 32'hFFC; we = 1'b0;
    #1;
    checks++;
    if (halt !== 1'b0) begin errors++; $display("[TB] FAIL halt_pre: got %b expected 0", halt); end
    tick();
    address = 32'h010;
    #1;
    checks++;
    if (halt !== 1'b1) begin errors++; $display("[TB] FAIL halt_set: got %b expected 1", halt); end
    tx_ready = 1'b1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 32'h55)
      begin errors++; $display("[TB] FAIL halt_drain: got valid=%b data=%h expected valid=1 data=00000055", tx_valid, tx_data); end
    tick();
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_drained: got %b expected 0", tx_valid); end
    repeat (3) tick();
    checks++;
    if (halt !== 1'b1) begin errors++; $display("[TB] FAIL halt_sticky: got %b expected 1", halt); end
    push_word(32'h66);
    push_word(32'h67);
    address = 32'h010;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if (halt !== 1'b0 || tx_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL halt_reset: got halt=%b valid=%b expected 0 0", halt, tx_valid); end
  endtask

  task automatic test_random();
    int unsigned op;
    for (int n = 0; n < 400; n++) begin
      op       = $urandom_range(0, 9);
      tx_ready = ($urandom_range(0, 9) < 3);
      if (op < 5) begin
        address = 32'h800;
        we = $urandom_range(0, 1);
        data_out = $urandom;
      end else if (op < 7) begin
        address = 32'h804;
        we = ($urandom_range(0, 3) == 0);
        data_out = $urandom;
      end else if (op < 8) begin
        address = 32'h808; we = 1'b0;
      end else begin
        address = 32'h020 + 32'($urandom_range(0, 3) * 4);
        we = $urandom_range(0, 1);
        data_out = $urandom;
      end
      #1;
      checks++;
      if (tx_valid !== (q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_valid_%0d: got %b expected %b", n, tx_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if (tx_data !== q[0]) begin errors++; $display("[TB] FAIL rnd_data_%0d: got %h expected %h", n, tx_data, q[0]); end
      end
      checks++;
      if (mem_we !== (we && !address[11])) begin errors++; $display("[TB] FAIL rnd_mem_we_%0d: got %b expected %b", n, mem_we, we && !address[11]); end
      checks++;
      if (halt !== m_halt) begin errors++; $display("[TB] FAIL rnd_halt_%0d: got %b expected %b", n, halt, m_halt); end
      if (address == 32'h804) begin
        checks++;
        if (data_in !== exp_status()) begin errors++; $display("[TB] FAIL rnd_status_%0d: got %h expected %h", n, data_in, exp_status()); end
      end else if (address == 32'h808) begin
        checks++;
        if (data_in !== exp_cycles()) begin errors++; $display("[TB] FAIL rnd_cycles_%0d: got %h expected %h", n, data_in, exp_cycles()); end
      end else if (address == 32'h800) begin
        checks++;
        if (data_in !== 32'h0) begin errors++; $display("[TB] FAIL rnd_txdata_read_%0d: got %h expected 0", n, data_in); end
      end
      tick();
    end
    we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mem_access();
    test_held_write();
    test_overflow();
    test_full_push_pop();
    test_cycles();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_bridge.md
# io_bridge

Memory-mapped I/O bridge on the shared single-port bus between `core` and `memory`. Decodes each access: ordinary addresses go to `memory` unchanged; the I/O window (address bit 11 = 1) is served locally. The I/O window contains a TX FIFO that drains over a valid/ready stream, a status/control register, a cycle counter and a sticky halt flag raised by any access to 0xFFC.

## Interface
Parameters:
- `DEPTH`, 8: TX FIFO entries; power of two, 2..64.
- `AW`, 32: bus address width.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset; one clock domain; reset is synchronous and active-low.
- `address`  in  AW  core bus address.
- `data_out`  in  32  core write data.
- `we`  in  1  core write enable.
- `data_in`  out  32  read data returned to core.
- `mem_we`  out  1  write enable to `memory`.
- `mem_rdata`  in  32  read data from `memory`.
- `tx_valid`  out  1  TX stream word available.
- `tx_data`  out  32  TX stream word (FIFO head).
- `tx_ready`  in  1  downstream accepts word.
- `halt`  out  1  sticky halt request.

## Operation
- Window select: `io_sel = address[11]`. When `io_sel`=0: `mem_we = we`, `data_in = mem_rdata`. When `io_sel`=1: `mem_we = 0` and `data_in` comes from the register map. Unmapped window addresses read 0 and ignore writes.
- Register map (word addresses; `address[1:0]` ignored):
  - 0x800 TXDATA: a write pushes `data_out`. Reads return 0.
  - 0x804 STATUS: returns {16'b0, count[7:0], 5'b0, overflow, full, empty}. Any write clears `overflow`.
  - 0x808 CYCLES: returns the 32-bit free-running counter. Writes are ignored.
  - 0xFFC HALT: any read or write sets `halt`.
- Write de-duplication: the core may hold a write for several cycles. A push or a STATUS clear occurs only on the first cycle of a write strobe. The first cycle is a cycle where `we`=1 and the previous cycle did not have both `we`=1 and the same `address`. Track this with a registered `prev_we` and `prev_addr`.
- FIFO:
  - `tx_valid = !empty`; `tx_data` = head entry.
  - Pop occurs when `tx_valid && tx_ready`.
  - Push when full and no pop in the same cycle: the word is dropped and `overflow` is set (sticky).
  - Push when full with a simultaneous pop: the push is accepted and count stays the same.
  - Push when empty: the word appears on `tx_data` the next cycle. There is no fall-through.
  - Read and write pointers wrap modulo DEPTH. `count` ranges 0..DEPTH.
- Halt: `halt` stays set until reset. After halt, FIFO draining continues.

## Timing
- Reset values: `tx_valid`=0, `halt`=0, `overflow`=0, count=0, pointers=0, cycle counter=0, `prev_we`=0.
- `data_in` and `mem_we` are combinational from `address`/`we`, with zero latency, so `memory` and the core see the same cycle.
- Push-to-`tx_valid` latency: 1 cycle. Pop updates head and count on the next edge.
- STATUS reads show the pre-edge registered state. A push in the current cycle is not yet visible.
- Cycle counter increments every cycle after reset and wraps from 0xFFFFFFFF to 0.
- Reset in mid-stream flushes the FIFO: `tx_valid` is 0 on the first cycle after reset is released.

## Configuration
- `IO_BRIDGE_CYCLE_COUNTER_EN`:
  - Defined: the 32-bit counter exists and CYCLES returns its value.
  - Undefined: no counter flops are built and CYCLES reads 0.

## Structure
- Package `io_bridge_pkg`: address constants IO_TXDATA=0x800, IO_STATUS=0x804, IO_CYCLES=0x808, IO_HALT=0xFFC; STATUS bit-position constants; `io_sel` bit index 11.
- Sub-module `sync_fifo` (parameters DEPTH, WIDTH): push/pop/full/empty/count and dropped-push detection. `io_bridge` holds the decode, de-dup, status, counter and halt logic.

## Test plan
- Plain memory access: write 0x1234 to 0x010, then read 0x010. Required: `mem_we`=1 on the write, read returns 0x1234, `tx_valid` stays 0.
- Held write: `we`=1 at 0x800 with data 0xA5 for 3 cycles, `tx_ready`=0. Required: STATUS count=1, and `tx_data`=0xA5 one cycle after the first write cycle.
- Overflow: push 9 distinct words (DEPTH=8) with `tx_ready`=0. Required: STATUS=0x0000_0806 (count 8, overflow, full). Raise `tx_ready`: words 1..8 drain in order and `tx_valid` then drops. A write to 0x804 clears `overflow`.
- Full with simultaneous push and pop: FIFO full, `tx_ready`=1, push 0x77. Required: count stays 8, `overflow` stays 0, 0x77 is the last word out.
- Halt: read 0xFFC. Required: `halt`=1 from the next cycle and it persists. Pulse `resetn` low for 1 cycle: `halt`=0 and the FIFO is empty.
- Cycle counter: read 0x808 at two points 10 cycles apart. Required: the difference is 10 with the macro defined, and both reads are 0 without it.
